// File: rtl/irq_pkg.sv
// Shared constants and types for the machine-mode interrupt controller.
`ifndef XLEN
`define XLEN 32
`endif

package irq_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam logic [11:0] IRQ_MASK = 12'h888;

  typedef enum logic [1:0] {IDLE, REQ, HANDLER} irq_state_t;

  // Fixed priority: external, then software, then timer.
  function automatic logic [3:0] irq_pick(input logic [11:0] pend);
    if (pend[IRQ_MEI])      return IRQ_MEI;
    else if (pend[IRQ_MSI]) return IRQ_MSI;
    else                    return IRQ_MTI;
  endfunction

endpackage

// File: rtl/m_sync_ff.sv
// Multi-flop level synchronizer with synchronous active-low clear.
module m_sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], i_d};
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/m_irq_ctrl.sv
// Machine-mode interrupt controller: mstatus.MIE/MPIE, mie, mip view,
// prioritised trap request with a cause frozen until the core acks.
`ifndef XLEN
`define XLEN 32
`endif

module m_irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned XLEN        = `XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_tip,
  input  logic            i_sip,
  input  logic            i_eip,
  input  logic            i_csr_wen,
  input  logic            i_csr_ren,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_csr_hit,
  output logic            o_irq_req,
  output logic [XLEN-1:0] o_irq_cause,
  input  logic            i_irq_ack,
  input  logic            i_mret
);

  irq_state_t      state_q, state_d;
  logic            mie_bit_q, mie_bit_d;
  logic            mpie_q, mpie_d;
  logic [11:0]     mie_q, mie_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic            eip_sync;
  logic [11:0]     mip;
  logic [11:0]     pend;
  logic [11:0]     rd_val;
  logic [XLEN-1:0] cause_word;
  logic            ack_take;
  logic            unused_wdata;

  m_sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_eip_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_eip),
    .o_q   (eip_sync)
  );

  always_comb begin
    mip          = '0;
    mip[IRQ_MSI] = i_sip;
    mip[IRQ_MTI] = i_tip;
    mip[IRQ_MEI] = eip_sync;
  end

  assign pend     = mip & mie_q & {12{mie_bit_q}};
  assign ack_take = (state_q == REQ) && i_irq_ack;

  always_comb begin
    cause_word         = '0;
    cause_word[XLEN-1] = 1'b1;
    cause_word[3:0]    = irq_pick(pend);
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    mie_bit_d = mie_bit_q;
    mpie_d    = mpie_q;
    mie_d     = mie_q;

    if (i_csr_wen && (i_csr_addr == CSR_MIE)) mie_d = i_csr_wdata[11:0] & IRQ_MASK;

    // Trap entry beats mret, and both beat a software write to mstatus.
    if (ack_take) begin
      mpie_d    = mie_bit_q;
      mie_bit_d = 1'b0;
    end else if (i_mret) begin
      mie_bit_d = mpie_q;
      mpie_d    = 1'b1;
    end else if (i_csr_wen && (i_csr_addr == CSR_MSTATUS)) begin
      mie_bit_d = i_csr_wdata[3];
      mpie_d    = i_csr_wdata[7];
    end

    unique case (state_q)
      IDLE: begin
        if (|pend) begin
          state_d = REQ;
          cause_d = cause_word;
        end
      end
      REQ: begin
        if (i_irq_ack)   state_d = HANDLER;
        else if (~|pend) state_d = IDLE;
      end
      HANDLER: begin
        if (i_mret) begin
          state_d = IDLE;
        end else if (|pend) begin
          state_d = REQ;
          cause_d = cause_word;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      cause_q   <= '0;
      mie_bit_q <= 1'b0;
      mpie_q    <= 1'b0;
      mie_q     <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      mie_bit_q <= mie_bit_d;
      mpie_q    <= mpie_d;
      mie_q     <= mie_d;
    end
  end

  assign o_csr_hit = (i_csr_addr == CSR_MSTATUS) || (i_csr_addr == CSR_MIE) ||
                     (i_csr_addr == CSR_MIP);

  always_comb begin
    rd_val = '0;
    if (i_csr_ren) begin
      unique case (i_csr_addr)
        CSR_MSTATUS: begin
          rd_val[3] = mie_bit_q;
          rd_val[7] = mpie_q;
        end
        CSR_MIE: rd_val = mie_q;
        CSR_MIP: rd_val = mip;
        default: rd_val = '0;
      endcase
    end
  end

  assign o_csr_rdata  = XLEN'(rd_val);
  assign o_irq_req    = (state_q == REQ);
  assign o_irq_cause  = cause_q;
  assign unused_wdata = ^i_csr_wdata[XLEN-1:12];

endmodule

// File: tb/tb_m_irq_ctrl.sv
// Directed and randomized bench for m_irq_ctrl against a behavioural model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_m_irq_ctrl;

  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        rst, tip, sip, eip, wen, ren, ack, mret;
  logic [11:0] csr_addr;
  logic [31:0] wdata, rdata, cause;
  logic        hit, req;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  bit          m_mie_bit, m_mpie;
  logic [11:0] m_mie;
  int          m_mode;           // 0 idle, 1 request pending, 2 in handler
  logic [31:0] m_cause;
  bit          eip_line[$];      // delay line: back is the synchronized value

  m_irq_ctrl #(
    .SYNC_STAGES (SYNC),
    .XLEN        (32)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_tip       (tip),
    .i_sip       (sip),
    .i_eip       (eip),
    .i_csr_wen   (wen),
    .i_csr_ren   (ren),
    .i_csr_addr  (csr_addr),
    .i_csr_wdata (wdata),
    .o_csr_rdata (rdata),
    .o_csr_hit   (hit),
    .o_irq_req   (req),
    .o_irq_cause (cause),
    .i_irq_ack   (ack),
    .i_mret      (mret)
  );

  always #10 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] m_pend();
    int mip;
    mip = (int'(sip) << 3) + (int'(tip) << 7) + (int'(eip_line[$]) << 11);
    return m_mie_bit ? (12'(mip) & m_mie) : 12'h0;
  endfunction

  function automatic logic [31:0] m_rd(input logic r, input logic [11:0] a);
    if (!r) return 0;
    if (a == 12'h300) return (32'(m_mpie) << 7) + (32'(m_mie_bit) << 3);
    if (a == 12'h304) return 32'(m_mie);
    if (a == 12'h344) return (32'(sip) << 3) + (32'(tip) << 7) + (32'(eip_line[$]) << 11);
    return 0;
  endfunction

  task automatic model_step();
    logic [11:0] p;
    bit take;
    p = m_pend();
    if (!rst) begin
      m_mie_bit = 0; m_mpie = 0; m_mie = 0; m_mode = 0; m_cause = 0;
      eip_line.delete();
      for (int i = 0; i < SYNC; i++) eip_line.push_back(1'b0);
      return;
    end
    take = (m_mode == 1) && ack;
    if (wen && csr_addr == 12'h304) m_mie = wdata[11:0] & 12'h888;
    if (take) begin
      m_mpie = m_mie_bit; m_mie_bit = 0;
    end else if (mret) begin
      m_mie_bit = m_mpie; m_mpie = 1;
    end else if (wen && csr_addr == 12'h300) begin
      m_mie_bit = wdata[3]; m_mpie = wdata[7];
    end
    if ((m_mode == 0 || (m_mode == 2 && !mret)) && p != 0) begin
      m_mode  = 1;
      m_cause = 32'h8000_0000 + (p[11] ? 11 : (p[3] ? 3 : 7));
    end else if (m_mode == 1) begin
      if (ack) m_mode = 2;
      else if (p == 0) m_mode = 0;
    end else if (m_mode == 2 && mret) begin
      m_mode = 0;
    end
    eip_line.push_front(eip);
    void'(eip_line.pop_back());
  endtask

  task automatic compare_all();
    chk("req", 32'(req), 32'(m_mode == 1));
    chk("cause", cause, m_cause);
    chk("rdata", rdata, m_rd(ren, csr_addr));
    chk("hit", 32'(hit), 32'(csr_addr == 12'h300 || csr_addr == 12'h304 || csr_addr == 12'h344));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wen = 1; csr_addr = a; wdata = d;
    cycle();
    wen = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    ren = 1; csr_addr = a;
    #1;
    chk(tag, rdata, exp);
    ren = 0;
  endtask

  initial begin
    int n;
    bit got;
    logic [11:0] addrs [4];
    rst = 0; tip = 0; sip = 0; eip = 0; wen = 0; ren = 0; ack = 0; mret = 0;
    csr_addr = 0; wdata = 0;
    m_mie_bit = 0; m_mpie = 0; m_mie = 0; m_mode = 0; m_cause = 0;
    for (int i = 0; i < SYNC; i++) eip_line.push_back(1'b0);
    addrs[0] = 12'h300; addrs[1] = 12'h304; addrs[2] = 12'h344; addrs[3] = 12'h345;

    // Reset
    cycle(); cycle();
    rd_chk("rst_mstatus", 12'h300, 32'h0);
    rd_chk("rst_mie", 12'h304, 32'h0);
    rd_chk("rst_mip", 12'h344, 32'h0);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_cause", cause, 32'h0);
    rst = 1;

    // Timer interrupt, ack, mret
    wr(12'h304, 32'h80);
    wr(12'h300, 32'h8);
    tip = 1;
    cycle();
    chk("tmr_req", 32'(req), 32'h1);
    chk("tmr_cause", cause, 32'h8000_0007);
    ack = 1; tip = 0;
    cycle();
    ack = 0;
    chk("tmr_ack_req", 32'(req), 32'h0);
    rd_chk("tmr_ack_mstatus", 12'h300, 32'h80);
    mret = 1;
    cycle();
    mret = 0;
    rd_chk("tmr_mret_mstatus", 12'h300, 32'h88);

    // Priority and frozen cause
    wr(12'h304, 32'h888);
    tip = 1; sip = 1;
    cycle();
    chk("prio_req", 32'(req), 32'h1);
    chk("prio_cause", cause, 32'h8000_0003);
    eip = 1;
    repeat (4) cycle();
    chk("freeze_cause", cause, 32'h8000_0003);
    ack = 1;
    cycle();
    ack = 0;
    chk("freeze_ack_req", 32'(req), 32'h0);
    tip = 0; sip = 0; eip = 0;
    repeat (3) cycle();
    mret = 1;
    cycle();
    mret = 0;

    // External interrupt synchronizer latency
    wr(12'h304, 32'h800);
    eip = 1; n = 0; got = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      cycle();
      if (req) begin n = k; got = 1; end
    end
    chk("eip_latency", 32'(n), 32'(SYNC + 1));
    chk("eip_cause", cause, 32'h8000_000B);
    eip = 0; ack = 1;
    cycle();
    ack = 0;
    repeat (3) cycle();
    mret = 1;
    cycle();
    mret = 0;

    // Withdrawal before ack
    wr(12'h304, 32'h80);
    wr(12'h300, 32'h8);
    tip = 1;
    cycle();
    chk("wd_req", 32'(req), 32'h1);
    tip = 0;
    cycle();
    chk("wd_req_drop", 32'(req), 32'h0);
    rd_chk("wd_mstatus", 12'h300, 32'h8);

    // Collisions and read-only / masked writes
    tip = 1;
    cycle();
    chk("col_req", 32'(req), 32'h1);
    ack = 1;
    wr(12'h300, 32'h8);
    ack = 0; tip = 0;
    rd_chk("col_ack_mstatus", 12'h300, 32'h80);
    sip = 1;
    wr(12'h344, 32'hFFF);
    rd_chk("mip_ro", 12'h344, 32'h8);
    sip = 0;
    wr(12'h300, 32'hFFFF_FFFF);
    rd_chk("mstatus_mask", 12'h300, 32'h88);
    csr_addr = 12'h305; #1;
    chk("hit_miss", 32'(hit), 32'h0);
    csr_addr = 12'h304; #1;
    chk("hit_mie", 32'(hit), 32'h1);
    csr_addr = 12'h300; ren = 0; #1;
    chk("rd_no_ren", rdata, 32'h0);
    mret = 1; ack = 1;
    cycle();
    mret = 0; ack = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 99) != 0);
      tip   = ($urandom_range(0, 3) == 0);
      sip   = ($urandom_range(0, 4) == 0);
      eip   = ($urandom_range(0, 3) == 0);
      wen   = ($urandom_range(0, 5) == 0);
      ren   = $urandom_range(0, 1);
      csr_addr = addrs[$urandom_range(0, 3)];
      wdata = $urandom;
      if (wen && csr_addr == 12'h300 && $urandom_range(0, 1)) wdata[3] = 1'b1;
      ack   = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      mret  = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
